axon_array_ctrl: RTL and testbench
==================================

# axon_array_ctrl

Sequencer for the DIMENSION×DIMENSION AXON PE array. For each tile it clears the PE accumulators and streams k_len ifmap/weight vectors from the operand RAMs into the array edge. It then flushes the systolic skew and drains the DIMENSION result rows to the output RAM. It sits between the tile scheduler (start/done) and the array/RAM datapath, and is the only block that drives array enables and operand/output RAM addresses.

## Interface
- DIMENSION, 16, array rows/columns; output row count per tile
- ADDR_WIDTH, 10, operand and output RAM address width
- K_WIDTH, 10, width of reduction-length field
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  tile start request; sampled only in IDLE
- k_len  in  K_WIDTH  reduction steps for the tile; latched on accepted start
- ifmap_base, weight_base, out_base  in  ADDR_WIDTH each  base addresses; latched on accepted start
- stall  in  1  datapath/RAM not ready; freezes sequencing
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  one-cycle pulse, tile complete
- cfg_err  out  1  one-cycle pulse, start rejected because k_len==0
- acc_clr  out  1  clear all PE accumulators
- rd_en  out  1  operand RAM read strobe
- ifmap_addr, weight_addr  out  ADDR_WIDTH each  operand read addresses
- pe_en  out  1  array compute/shift enable
- out_we  out  1  output RAM write strobe
- out_sel  out  $clog2(DIMENSION)  array output row selected for drain
- out_addr  out  ADDR_WIDTH  output write address

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE. Outputs are Moore-decoded from the state and counters. The only exception is the stall gating described below.
- IDLE:
  - start=1 with k_len!=0 latches all configuration inputs and moves to CLEAR.
  - start=1 with k_len==0 pulses cfg_err next cycle and stays in IDLE.
  - start while not in IDLE is ignored.
- CLEAR: acc_clr=1 for exactly one cycle, then FEED. Not stallable.
- FEED:
  - rd_en=1 and pe_en=1.
  - ifmap_addr=ifmap_base+kcnt and weight_addr=weight_base+kcnt, with kcnt running 0..k_len-1.
  - After kcnt=k_len-1 is issued, go to FLUSH.
- FLUSH: pe_en=1 for 2·DIMENSION−1 active cycles. This covers 1 cycle of RAM read latency plus 2·(DIMENSION−1) of skew. Then go to DRAIN.
- DRAIN:
  - out_we=1 with out_sel running 0..DIMENSION−1 and out_addr=out_base+out_sel.
  - After the last row, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Stall:
  - While stall=1 in FEED, FLUSH or DRAIN, all counters and the state hold.
  - rd_en, pe_en and out_we are forced to 0, combinationally from stall.
  - Addresses and out_sel hold their values.
- Address arithmetic is modulo 2^ADDR_WIDTH, so it wraps silently.
- Reset (asynchronous, including mid-tile) forces IDLE and clears all counters and latched config. No done pulse is produced for an aborted tile.

## Timing
- Reset values: busy=0, done=0, cfg_err=0, acc_clr=0, rd_en=0, pe_en=0, out_we=0. All address outputs and out_sel are 0.
- Cycle 0 is the clock edge that accepts start. With no stall:
  - CLEAR is cycle 1.
  - FEED is cycles 2..k_len+1.
  - FLUSH is cycles k_len+2..k_len+2·DIMENSION.
  - DRAIN is cycles k_len+2·DIMENSION+1..k_len+3·DIMENSION.
  - done is asserted in cycle k_len+3·DIMENSION+1.
- Each stalled cycle adds exactly one cycle to the total latency.
- Back-to-back tiles: start may be asserted during the done cycle. It is accepted only on the following edge, from IDLE, so there is a minimum of one IDLE cycle between tiles.

## Configuration
- AXON_CTRL_PERF_EN defined:
  - Adds output port perf_cycles [31:0] and output port perf_stalls [31:0].
  - Both clear on an accepted start.
  - perf_cycles increments on every busy cycle; perf_stalls increments on every busy cycle with stall=1.
  - Both saturate at 32'hFFFF_FFFF and hold their value after done until the next start. Reset value is 0.
- Not defined: neither port exists, and no counter logic is present.

## Test plan
- DIMENSION=16, k_len=4, bases 0x010/0x020/0x100, no stall:
  - acc_clr at cycle 1.
  - rd_en cycles 2–5 with ifmap_addr 0x010–0x013 and weight_addr 0x020–0x023.
  - pe_en cycles 2–36.
  - out_we cycles 37–52 with out_addr 0x100–0x10F.
  - done at cycle 53.
- Same tile with stall=1 for 3 cycles at cycle 4 and 2 cycles at cycle 40:
  - No rd_en/pe_en/out_we while stalled, addresses held.
  - done at cycle 58.
- start with k_len=0: cfg_err pulses at cycle 1, busy stays 0, no strobes.
- start pulsed in mid-FEED: ignored, tile timing unchanged.
- ifmap_base=0x3FE, k_len=4: ifmap_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- rst_n asserted mid-DRAIN: all outputs 0 immediately, no done pulse. A new start after release then runs a full tile with nominal timing.

Source files
------------

// File: rtl/axon_array_ctrl.sv
// Tile sequencer for the AXON PE array: clears accumulators, feeds k_len operands, flushes skew, drains rows.
// Optional macro AXON_CTRL_PERF_EN adds saturating busy/stall cycle counters (perf_cycles, perf_stalls).
module axon_array_ctrl #(
    parameter int DIMENSION  = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int K_WIDTH    = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [K_WIDTH-1:0]           k_len,
    input  logic [ADDR_WIDTH-1:0]        ifmap_base,
    input  logic [ADDR_WIDTH-1:0]        weight_base,
    input  logic [ADDR_WIDTH-1:0]        out_base,
    input  logic                         stall,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic                         acc_clr,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        ifmap_addr,
    output logic [ADDR_WIDTH-1:0]        weight_addr,
    output logic                         pe_en,
    output logic                         out_we,
    output logic [$clog2(DIMENSION)-1:0] out_sel,
    output logic [ADDR_WIDTH-1:0]        out_addr
`ifdef AXON_CTRL_PERF_EN
    ,
    output logic [31:0]                  perf_cycles,
    output logic [31:0]                  perf_stalls
`endif
);

    localparam int SEL_W = $clog2(DIMENSION);
    localparam int FL_W  = $clog2(2 * DIMENSION);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(2 * DIMENSION - 2);
    localparam logic [SEL_W-1:0] ROW_LAST   = SEL_W'(DIMENSION - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t                r_state, w_next;
    logic [K_WIDTH-1:0]    r_k_len, r_kcnt;
    logic [ADDR_WIDTH-1:0] r_ifmap_base, r_weight_base, r_out_base;
    logic [FL_W-1:0]       r_fcnt;
    logic [SEL_W-1:0]      r_row;
    logic                  r_cfg_err;
    logic                  w_accept, w_reject, w_k_last, w_f_last, w_r_last;

    assign w_accept = (r_state == S_IDLE) && start && (k_len != '0);
    assign w_reject = (r_state == S_IDLE) && start && (k_len == '0);
    assign w_k_last = (r_kcnt == r_k_len - K_WIDTH'(1));
    assign w_f_last = (r_fcnt == FLUSH_LAST);
    assign w_r_last = (r_row == ROW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        busy    = (r_state != S_IDLE);
        done    = 1'b0;
        acc_clr = 1'b0;
        rd_en   = 1'b0;
        pe_en   = 1'b0;
        out_we  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CLEAR;
            S_CLEAR: begin
                acc_clr = 1'b1;
                w_next  = S_FEED;
            end
            S_FEED: begin
                rd_en = !stall;
                pe_en = !stall;
                if (!stall && w_k_last) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                pe_en = !stall;
                if (!stall && w_f_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                out_we = !stall;
                if (!stall && w_r_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Counters only advance on unstalled cycles, so addresses and out_sel hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k_len       <= '0;
            r_kcnt        <= '0;
            r_ifmap_base  <= '0;
            r_weight_base <= '0;
            r_out_base    <= '0;
            r_fcnt        <= '0;
            r_row         <= '0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_cfg_err <= w_reject;
            if (w_accept) begin
                r_k_len       <= k_len;
                r_ifmap_base  <= ifmap_base;
                r_weight_base <= weight_base;
                r_out_base    <= out_base;
                r_kcnt        <= '0;
                r_fcnt        <= '0;
                r_row         <= '0;
            end else if (!stall) begin
                case (r_state)
                    S_FEED:  if (!w_k_last) r_kcnt <= r_kcnt + K_WIDTH'(1);
                    S_FLUSH: if (!w_f_last) r_fcnt <= r_fcnt + FL_W'(1);
                    S_DRAIN: if (!w_r_last) r_row  <= r_row + SEL_W'(1);
                    default: ;
                endcase
            end
        end
    end

    assign cfg_err     = r_cfg_err;
    assign ifmap_addr  = r_ifmap_base + ADDR_WIDTH'(r_kcnt);
    assign weight_addr = r_weight_base + ADDR_WIDTH'(r_kcnt);
    assign out_sel     = r_row;
    assign out_addr    = r_out_base + ADDR_WIDTH'(r_row);

`ifdef AXON_CTRL_PERF_EN
    logic [31:0] r_perf_cycles, r_perf_stalls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (w_accept) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (r_state != S_IDLE) begin
            if (r_perf_cycles != '1)          r_perf_cycles <= r_perf_cycles + 32'd1;
            if (stall && r_perf_stalls != '1) r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_axon_array_ctrl.sv
// Directed bench for axon_array_ctrl: per-cycle strobe/address checks against a progress-count model.
module tb_axon_array_ctrl;
    localparam int D  = 16;
    localparam int AW = 10;
    localparam int KW = 10;

    logic          clk, rst_n, start, stall;
    logic [KW-1:0] k_len;
    logic [AW-1:0] ifmap_base, weight_base, out_base;
    logic          busy, done, cfg_err, acc_clr, rd_en, pe_en, out_we;
    logic [AW-1:0] ifmap_addr, weight_addr, out_addr;
    logic [3:0]    out_sel;
`ifdef AXON_CTRL_PERF_EN
    logic [31:0]   perf_cycles, perf_stalls;
`endif

    int checks   = 0;
    int failures = 0;

    axon_array_ctrl #(.DIMENSION(D), .ADDR_WIDTH(AW), .K_WIDTH(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .ifmap_base(ifmap_base), .weight_base(weight_base), .out_base(out_base),
        .stall(stall), .busy(busy), .done(done), .cfg_err(cfg_err), .acc_clr(acc_clr),
        .rd_en(rd_en), .ifmap_addr(ifmap_addr), .weight_addr(weight_addr), .pe_en(pe_en),
        .out_we(out_we), .out_sel(out_sel), .out_addr(out_addr)
`ifdef AXON_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Vector bit order: busy, cfg_err, acc_clr, rd_en, pe_en, out_we, done
    function automatic logic [6:0] strobes();
        return {busy, cfg_err, acc_clr, rd_en, pe_en, out_we, done};
    endfunction

    // Runs one tile from the current (off-edge) time; cycle c is the interval after edge c-1.
    task automatic run_tile(input string nm, input int k, input logic [AW-1:0] ib,
                            input logic [AW-1:0] wb, input logic [AW-1:0] ob,
                            input int s1c, input int s1n, input int s2c, input int s2n,
                            input int mid_c, input bit b2b, input int exp_done);
        int total, pos, done_cyc, row;
        bit fin, st;
        logic [6:0]    e_vec;
        logic [AW-1:0] e_a, e_b;
        total = k + 3 * D - 1;
        pos = 0; fin = 0; done_cyc = -1;
        k_len = KW'(k); ifmap_base = ib; weight_base = wb; out_base = ob;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= exp_done + 1; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            st    = (c >= s1c && c < s1c + s1n) || (c >= s2c && c < s2c + s2n);
            stall = st;
            start = (c == mid_c) || (b2b && c >= exp_done);
            e_vec = 7'b0;
            if (c == 1)                 e_vec = 7'b1010000;
            else if (fin)               e_vec = 7'b0000000;
            else if (pos == total)      e_vec = 7'b1000001;
            else if (pos < k)           e_vec = st ? 7'b1000000 : 7'b1001100;
            else if (pos < k + 2*D - 1) e_vec = st ? 7'b1000000 : 7'b1000100;
            else                        e_vec = st ? 7'b1000000 : 7'b1000010;
            @(negedge clk);
            checks++;
            if (strobes() !== e_vec) begin
                failures++;
                $display("FAIL %s strobes cycle %0d: got %b want %b", nm, c, strobes(), e_vec);
            end
            if (c >= 2 && !fin && pos < k) begin
                e_a = ib + AW'(pos);
                e_b = wb + AW'(pos);
                checks++;
                if (ifmap_addr !== e_a || weight_addr !== e_b) begin
                    failures++;
                    $display("FAIL %s feed_addr cycle %0d: got %h/%h want %h/%h",
                             nm, c, ifmap_addr, weight_addr, e_a, e_b);
                end
            end
            if (c >= 2 && !fin && pos >= k + 2*D - 1 && pos < total) begin
                row = pos - (k + 2*D - 1);
                e_a = ob + AW'(row);
                checks++;
                if (out_sel !== 4'(row) || out_addr !== e_a) begin
                    failures++;
                    $display("FAIL %s drain cycle %0d: got sel %0d addr %h want sel %0d addr %h",
                             nm, c, out_sel, out_addr, row, e_a);
                end
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (c >= 2 && !fin) begin
                if (pos == total) fin = 1;
                else if (!st)     pos++;
            end
        end
        stall = 1'b0;
        if (!b2b) start = 1'b0;
        checks++;
        if (done_cyc != exp_done) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d want %0d", nm, done_cyc, exp_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; k_len = '0;
        ifmap_base = '0; weight_base = '0; out_base = '0;
        #12;
        checks++;
        if ({strobes(), ifmap_addr, weight_addr, out_sel, out_addr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b/%h/%h/%h/%h want all zero",
                     strobes(), ifmap_addr, weight_addr, out_sel, out_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cfg_err();
        k_len = '0; ifmap_base = 10'h010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            checks++;
            if (strobes() !== (c == 1 ? 7'b0100000 : 7'b0000000)) begin
                failures++;
                $display("FAIL cfg_err cycle %0d: got %b want %b", c, strobes(),
                         (c == 1 ? 7'b0100000 : 7'b0000000));
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        k_len = KW'(4); ifmap_base = 10'h010; weight_base = 10'h020; out_base = 10'h100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_we !== 1'b1 || out_sel !== 4'd3) begin
            failures++;
            $display("FAIL abort_pre_drain: got we %b sel %0d want 1 sel 3", out_we, out_sel);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({strobes(), ifmap_addr, weight_addr, out_sel, out_addr} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got %b/%h/%h/%h/%h want all zero",
                     strobes(), ifmap_addr, weight_addr, out_sel, out_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (strobes() !== 7'b0) begin
                failures++;
                $display("FAIL abort_hold %0d: got %b want 0000000", i, strobes());
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (strobes() !== 7'b0) begin
            failures++;
            $display("FAIL abort_release: got %b want 0000000", strobes());
        end
        run_tile("after_abort", 4, 10'h010, 10'h020, 10'h100, 0, 0, 0, 0, 0, 0, 53);
    endtask

    task automatic test_nominal();
        run_tile("nominal", 4, 10'h010, 10'h020, 10'h100, 0, 0, 0, 0, 0, 0, 53);
    endtask

    task automatic test_stall();
        run_tile("stall", 4, 10'h010, 10'h020, 10'h100, 4, 3, 40, 2, 0, 0, 58);
    endtask

    task automatic test_mid_start();
        run_tile("mid_start", 4, 10'h010, 10'h020, 10'h100, 0, 0, 0, 0, 3, 0, 53);
    endtask

    task automatic test_wrap();
        run_tile("wrap", 4, 10'h3FE, 10'h3FF, 10'h3F8, 0, 0, 0, 0, 0, 0, 53);
    endtask

    task automatic test_back_to_back();
        run_tile("b2b_first", 2, 10'h040, 10'h080, 10'h200, 0, 0, 0, 0, 0, 1, 51);
        run_tile("b2b_second", 2, 10'h040, 10'h080, 10'h200, 0, 0, 0, 0, 0, 0, 51);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_cfg_err();
        test_stall();
        test_mid_start();
        test_wrap();
        test_back_to_back();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
